// File: rtl/pe_mac_sequencer.sv
// Per-PE MAC sequencer: walks an S-tap filter window over the ifmap spad, skips zero-flagged taps,
// holds each psum until psum_ready is seen, then pulses shift to slide the spad by one entry.
module pe_mac_sequencer #(
  parameter int MEM_DEPTH  = 12,
  parameter int DATA_WIDTH = 16,
  parameter int PSUM_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [ADDR_WIDTH:0]             filt_len,
  input  logic [OUT_WIDTH-1:0]            num_out,
  input  logic [ADDR_WIDTH:0]             ifmap_count,
  input  logic                            zero_flag,
  input  logic [DATA_WIDTH-1:0]           ifmap_data,
  input  logic [DATA_WIDTH-1:0]           filt_data,
  output logic [ADDR_WIDTH-1:0]           ifmap_r_addr,
  output logic [ADDR_WIDTH-1:0]           filt_r_addr,
  output logic                            mac_en,
  output logic                            shift,
  output logic [PSUM_WIDTH-1:0]           psum_out,
  output logic                            psum_valid,
  input  logic                            psum_ready,
  output logic [OUT_WIDTH+ADDR_WIDTH-1:0] skip_count,
  output logic                            busy,
  output logic                            done,
  output logic                            cfg_err
);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_MAC, ST_OUT, ST_SHIFT, ST_DONE} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

  state_t                         state, state_nxt;
  logic [ADDR_WIDTH:0]            s_len;
  logic [OUT_WIDTH-1:0]           n_out;
  logic [OUT_WIDTH-1:0]           out_cnt;
  logic [ADDR_WIDTH-1:0]          k;
  logic signed [PSUM_WIDTH-1:0]   acc;
  logic                           err;
  logic                           cfg_bad;
  logic                           last_tap;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [PSUM_WIDTH-1:0]   prod_ext;

  assign cfg_bad  = (filt_len == '0) || (num_out == '0) || (filt_len > DEPTH);
  assign last_tap = ({1'b0, k} == s_len - 1'b1);
  assign prod     = $signed(ifmap_data) * $signed(filt_data);
  assign prod_ext = PSUM_WIDTH'(prod);
  assign psum_out = acc;

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    ifmap_r_addr = '0;
    filt_r_addr  = '0;
    mac_en       = 1'b0;
    shift        = 1'b0;
    psum_valid   = 1'b0;
    done         = 1'b0;
    cfg_err      = 1'b0;
    busy         = (state != ST_IDLE);
    case (state)
      ST_IDLE:  if (start) state_nxt = cfg_bad ? ST_DONE : ST_WAIT;
      ST_WAIT:  if (ifmap_count >= s_len) state_nxt = ST_MAC;
      ST_MAC: begin
        ifmap_r_addr = k;
        filt_r_addr  = k;
        mac_en       = !zero_flag;
        if (last_tap) state_nxt = ST_OUT;
      end
      ST_OUT: begin
        psum_valid = 1'b1;
        if (psum_ready) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        shift     = 1'b1;
        state_nxt = (out_cnt + 1'b1 == n_out) ? ST_DONE : ST_WAIT;
      end
      ST_DONE: begin
        done      = 1'b1;
        cfg_err   = err;
        state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Tap 0 restarts the accumulator, so a skipped first tap still clears the previous psum.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s_len      <= '0;
      n_out      <= '0;
      out_cnt    <= '0;
      k          <= '0;
      acc        <= '0;
      skip_count <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            err <= cfg_bad;
            if (!cfg_bad) begin
              s_len      <= filt_len;
              n_out      <= num_out;
              out_cnt    <= '0;
              skip_count <= '0;
            end
          end
        end
        ST_MAC: begin
          acc <= ((k == '0) ? '0 : acc) + (zero_flag ? '0 : prod_ext);
          k   <= last_tap ? '0 : k + 1'b1;
          if (zero_flag && (skip_count != '1)) skip_count <= skip_count + 1'b1;
        end
        ST_SHIFT: out_cnt <= out_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Directed bench for pe_mac_sequencer with a small ifmap spad / flag buffer / filter spad model.
module tb_pe_mac_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        psum_ready = 1'b1;
  logic [4:0]  filt_len = '0;
  logic [7:0]  num_out = '0;
  logic [4:0]  ifmap_count;
  logic        zero_flag;
  logic [15:0] ifmap_data, filt_data;
  logic [3:0]  ifmap_r_addr, filt_r_addr;
  logic        mac_en, shift, psum_valid, busy, done, cfg_err;
  logic [31:0] psum_out;
  logic [11:0] skip_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] psq[$];

  always #5 clk = ~clk;

  pe_mac_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .filt_len(filt_len), .num_out(num_out),
    .ifmap_count(ifmap_count), .zero_flag(zero_flag), .ifmap_data(ifmap_data),
    .filt_data(filt_data), .ifmap_r_addr(ifmap_r_addr), .filt_r_addr(filt_r_addr),
    .mac_en(mac_en), .shift(shift), .psum_out(psum_out), .psum_valid(psum_valid),
    .psum_ready(psum_ready), .skip_count(skip_count), .busy(busy), .done(done),
    .cfg_err(cfg_err)
  );

  // Spad model: shift drops entry 0; with refill enabled one word is appended the cycle after a shift.
  logic [15:0] ifm[12];
  logic        zf[12];
  logic [15:0] flt[12];
  logic [4:0]  cnt = '0;
  logic [15:0] ld_ifm[12];
  logic        ld_zf[12];
  logic [4:0]  ld_cnt = '0;
  logic [15:0] ld_base = '0;
  logic [15:0] stream = '0;
  logic        ld_go = 1'b0;
  logic        refill_en = 1'b0;
  logic        wr_pend = 1'b0;

  assign ifmap_count = cnt;
  assign ifmap_data  = ifm[ifmap_r_addr];
  assign zero_flag   = zf[ifmap_r_addr];
  assign filt_data   = flt[filt_r_addr];

  always @(posedge clk) begin
    wr_pend <= shift;
    if (ld_go) begin
      for (int i = 0; i < 12; i++) begin ifm[i] <= ld_ifm[i]; zf[i] <= ld_zf[i]; end
      cnt    <= ld_cnt;
      stream <= ld_base;
    end else if (shift) begin
      for (int i = 0; i < 11; i++) begin ifm[i] <= ifm[i+1]; zf[i] <= zf[i+1]; end
      ifm[11] <= '0;
      zf[11]  <= 1'b0;
      cnt     <= cnt - 1'b1;
    end else if (wr_pend && refill_en && cnt < 5'd12) begin
      ifm[cnt[3:0]] <= stream;
      zf[cnt[3:0]]  <= 1'b0;
      cnt           <= cnt + 1'b1;
      stream        <= stream + 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] a0, a1, a2, input logic z0, z1, z2,
                      input logic [15:0] f0, f1, f2, input logic [4:0] c, input logic [15:0] base);
    for (int i = 0; i < 12; i++) begin ld_ifm[i] = '0; ld_zf[i] = 1'b0; flt[i] = '0; end
    ld_ifm[0] = a0; ld_ifm[1] = a1; ld_ifm[2] = a2;
    ld_zf[0] = z0;  ld_zf[1] = z1;  ld_zf[2] = z2;
    flt[0] = f0;    flt[1] = f1;    flt[2] = f2;
    ld_cnt = c;
    ld_base = base;
    ld_go = 1'b1;
    step();
    ld_go = 1'b0;
  endtask

  task automatic start_row(input logic [4:0] s, input logic [7:0] n);
    filt_len = s;
    num_out  = n;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  // Observes one row; wc counts cycles that look like WAIT (busy with nothing else happening).
  task automatic run_row(input int budget, output int nm, output int ns, output int mask,
                         output int wc, output logic ov, output logic gd, output logic ed);
    nm = 0; ns = 0; mask = 0; wc = 0; ov = 1'b0; gd = 1'b0; ed = 1'b0;
    psq.delete();
    for (int c = 0; c < budget; c++) begin
      if (mac_en) begin nm++; mask |= (1 << ifmap_r_addr); end
      if (shift) ns++;
      if (mac_en && shift) ov = 1'b1;
      if (psum_valid && psum_ready) psq.push_back(psum_out);
      if (busy && !mac_en && !shift && !psum_valid && !done) wc++;
      if (done) begin gd = 1'b1; ed = cfg_err; step(); break; end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({mac_en, shift, psum_valid, done, cfg_err} !== 5'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 00000", {mac_en, shift, psum_valid, done, cfg_err}); end
    n_cmp++; if (psum_out !== 32'd0) begin n_bad++; $display("FAIL reset_psum: got %0h want 0", psum_out); end
    n_cmp++; if ({ifmap_r_addr, filt_r_addr, skip_count} !== 20'd0) begin n_bad++; $display("FAIL reset_addr_skip: got %0h want 0", {ifmap_r_addr, filt_r_addr, skip_count}); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic_mac();
    int nm, ns, mask, wc; logic ov, gd, ed; logic [31:0] p;
    load(16'd1, 16'd2, 16'd3, 1'b0, 1'b0, 1'b0, 16'd4, 16'd5, 16'd6, 5'd3, 16'd0);
    start_row(5'd3, 8'd1);
    run_row(40, nm, ns, mask, wc, ov, gd, ed);
    p = (psq.size() > 0) ? psq[0] : 32'hxxxxxxxx;
    n_cmp++; if (gd !== 1'b1) begin n_bad++; $display("FAIL basic_done: got %b want 1", gd); end
    n_cmp++; if (ed !== 1'b0) begin n_bad++; $display("FAIL basic_cfg_err: got %b want 0", ed); end
    n_cmp++; if (p !== 32'd32) begin n_bad++; $display("FAIL basic_psum: got %0d want 32", p); end
    n_cmp++; if (nm !== 3) begin n_bad++; $display("FAIL basic_mac_cnt: got %0d want 3", nm); end
    n_cmp++; if (mask !== 7) begin n_bad++; $display("FAIL basic_mac_taps: got %0h want 7", mask); end
    n_cmp++; if (ns !== 1) begin n_bad++; $display("FAIL basic_shift_cnt: got %0d want 1", ns); end
    n_cmp++; if (wc !== 1) begin n_bad++; $display("FAIL basic_wait_cycles: got %0d want 1", wc); end
    n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL basic_overlap: got %b want 0", ov); end
    n_cmp++; if (skip_count !== 12'd0) begin n_bad++; $display("FAIL basic_skip: got %0d want 0", skip_count); end
  endtask

  task automatic test_zero_skip();
    int nm, ns, mask, wc; logic ov, gd, ed; logic [31:0] p;
    load(16'd0, 16'd2, 16'd0, 1'b1, 1'b0, 1'b1, 16'd7, 16'd5, 16'd9, 5'd3, 16'd0);
    start_row(5'd3, 8'd1);
    run_row(40, nm, ns, mask, wc, ov, gd, ed);
    p = (psq.size() > 0) ? psq[0] : 32'hxxxxxxxx;
    n_cmp++; if (gd !== 1'b1) begin n_bad++; $display("FAIL skip_done: got %b want 1", gd); end
    n_cmp++; if (p !== 32'd10) begin n_bad++; $display("FAIL skip_psum: got %0d want 10", p); end
    n_cmp++; if (mask !== 2) begin n_bad++; $display("FAIL skip_mac_taps: got %0h want 2", mask); end
    n_cmp++; if (skip_count !== 12'd2) begin n_bad++; $display("FAIL skip_count: got %0d want 2", skip_count); end
  endtask

  task automatic test_stream();
    int nm, ns, mask, wc; logic ov, gd, ed;
    logic [31:0] exp_p[4];
    exp_p[0] = 32'd6; exp_p[1] = 32'd9; exp_p[2] = 32'd12; exp_p[3] = 32'd15;
    load(16'd1, 16'd2, 16'd3, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1, 16'd1, 5'd3, 16'd4);
    refill_en = 1'b1;
    start_row(5'd3, 8'd4);
    run_row(200, nm, ns, mask, wc, ov, gd, ed);
    refill_en = 1'b0;
    n_cmp++; if (gd !== 1'b1) begin n_bad++; $display("FAIL stream_done: got %b want 1", gd); end
    n_cmp++; if (psq.size() !== 4) begin n_bad++; $display("FAIL stream_npsum: got %0d want 4", psq.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < psq.size()) begin
        n_cmp++; if (psq[i] !== exp_p[i]) begin n_bad++; $display("FAIL stream_psum%0d: got %0d want %0d", i, psq[i], exp_p[i]); end
      end
    end
    n_cmp++; if (ns !== 4) begin n_bad++; $display("FAIL stream_shifts: got %0d want 4", ns); end
    n_cmp++; if (nm !== 12) begin n_bad++; $display("FAIL stream_macs: got %0d want 12", nm); end
    n_cmp++; if (wc !== 7) begin n_bad++; $display("FAIL stream_wait_cycles: got %0d want 7", wc); end
    n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL stream_overlap: got %b want 0", ov); end
  endtask

  task automatic test_backpressure();
    logic seen;
    seen = 1'b0;
    psum_ready = 1'b0;
    load(16'd3, 16'd4, 16'd0, 1'b0, 1'b0, 1'b0, 16'd5, 16'd6, 16'd0, 5'd2, 16'd0);
    start_row(5'd2, 8'd1);
    for (int c = 0; c < 20; c++) begin
      if (psum_valid) begin seen = 1'b1; break; end
      step();
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL bp_valid_timeout: got %b want 1", seen); end
    for (int j = 0; j < 6; j++) begin
      n_cmp++; if ({psum_valid, shift} !== 2'b10) begin n_bad++; $display("FAIL bp_hold%0d: got valid,shift=%b want 10", j, {psum_valid, shift}); end
      n_cmp++; if (psum_out !== 32'd39) begin n_bad++; $display("FAIL bp_psum%0d: got %0d want 39", j, psum_out); end
      if (j == 5) psum_ready = 1'b1;
      step();
    end
    n_cmp++; if ({psum_valid, shift} !== 2'b01) begin n_bad++; $display("FAIL bp_release: got valid,shift=%b want 01", {psum_valid, shift}); end
    step();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL bp_done: got %b want 1", done); end
    step();
  endtask

  task automatic test_wrap();
    int nm, ns, mask, wc; logic ov, gd, ed; logic [31:0] p;
    load(16'h8000, 16'h8000, 16'd0, 1'b0, 1'b0, 1'b0, 16'h8000, 16'h8000, 16'd0, 5'd2, 16'd0);
    start_row(5'd2, 8'd1);
    run_row(40, nm, ns, mask, wc, ov, gd, ed);
    p = (psq.size() > 0) ? psq[0] : 32'hxxxxxxxx;
    n_cmp++; if (p !== 32'h8000_0000) begin n_bad++; $display("FAIL wrap_psum: got %0h want 80000000", p); end
    n_cmp++; if (nm !== 2) begin n_bad++; $display("FAIL wrap_macs: got %0d want 2", nm); end
  endtask

  task automatic test_reset_mid();
    logic found;
    found = 1'b0;
    load(16'd1, 16'd2, 16'd3, 1'b0, 1'b0, 1'b0, 16'd4, 16'd5, 16'd6, 5'd3, 16'd0);
    start_row(5'd3, 8'd1);
    for (int c = 0; c < 10; c++) begin
      if (mac_en && ifmap_r_addr == 4'd1) begin found = 1'b1; break; end
      step();
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL rmid_reach_k1: got %b want 1", found); end
    reset = 1'b0;
    step();
    n_cmp++; if ({busy, mac_en, shift, psum_valid, done} !== 5'b0) begin n_bad++; $display("FAIL rmid_flags: got %b want 00000", {busy, mac_en, shift, psum_valid, done}); end
    n_cmp++; if (psum_out !== 32'd0) begin n_bad++; $display("FAIL rmid_psum: got %0d want 0", psum_out); end
    n_cmp++; if (ifmap_r_addr !== 4'd0) begin n_bad++; $display("FAIL rmid_addr: got %0d want 0", ifmap_r_addr); end
    reset = 1'b1;
    step();
    n_cmp++; if ({busy, psum_valid} !== 2'b00) begin n_bad++; $display("FAIL rmid_idle_after: got %b want 00", {busy, psum_valid}); end
  endtask

  task automatic test_cfg_err();
    logic [4:0] bs[3];
    logic [7:0] bn[3];
    bs[0] = 5'd0; bn[0] = 8'd1;
    bs[1] = 5'd3; bn[1] = 8'd0;
    bs[2] = 5'd13; bn[2] = 8'd1;
    for (int i = 0; i < 3; i++) begin
      start_row(bs[i], bn[i]);
      n_cmp++; if ({done, cfg_err, shift, mac_en} !== 4'b1100) begin n_bad++; $display("FAIL cfg%0d_pulse: got %b want 1100", i, {done, cfg_err, shift, mac_en}); end
      step();
      n_cmp++; if ({done, cfg_err, busy} !== 3'b000) begin n_bad++; $display("FAIL cfg%0d_after: got %b want 000", i, {done, cfg_err, busy}); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_mac();
    test_zero_skip();
    test_stream();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_cfg_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
